// File: rtl/div_seq_if.sv
// Handshake/bus bundle between the EX stage (master) and the div_seq sequencer (slave).
interface div_seq_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  start;
  logic                  annul;
  logic                  signed_div;
  logic [DATA_W-1:0]     opdata1;
  logic [DATA_W-1:0]     opdata2;
  logic [2*DATA_W-1:0]   result;
  logic                  ready;
  logic                  stallreq_c;

  modport master (
    output start, annul, signed_div, opdata1, opdata2,
    input  result, ready, stallreq_c
  );

  modport slave (
    input  start, annul, signed_div, opdata1, opdata2,
    output result, ready, stallreq_c
  );
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider sequencer for DIV/DIVU; one quotient bit per clock.
// Optional macro DIV_EARLY_OUT_EN: finish at once when |dividend| < |divisor|.
module div_seq #(
  parameter int unsigned DATA_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);
  localparam int unsigned W     = DATA_W;
  localparam int unsigned CNT_W = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_BY_ZERO, S_ON, S_END} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [W:0]         rem, rem_next;
  logic [W-1:0]       quo, quo_next;
  logic [W-1:0]       dvs, dvs_next;
  logic               neg_q, neg_q_next;
  logic               neg_r, neg_r_next;
  logic [2*W-1:0]     result_next;
  logic               ready_next;

  logic [W-1:0]       abs1, abs2;
  logic               accept, div_zero, early, last_iter;
  logic [W:0]         rem_sh;
  logic [W+1:0]       diff;
  logic               borrow;
  logic [W-1:0]       q_fix, r_fix;

  // Magnitudes are only taken for signed divides
  assign abs1 = (bus.signed_div && bus.opdata1[W-1]) ? W'(-bus.opdata1) : bus.opdata1;
  assign abs2 = (bus.signed_div && bus.opdata2[W-1]) ? W'(-bus.opdata2) : bus.opdata2;

  assign accept    = bus.start && !bus.annul;
  assign div_zero  = (bus.opdata2 == W'(0));
  assign last_iter = (cnt == CNT_W'(W));

`ifdef DIV_EARLY_OUT_EN
  assign early = !div_zero && (abs1 < abs2);
`else
  assign early = 1'b0;
`endif

  // One restoring step: shift left, trial-subtract the divisor
  assign rem_sh = {rem[W-1:0], quo[W-1]};
  assign diff   = {1'b0, rem_sh} - {2'b00, dvs};
  assign borrow = diff[W+1];

  assign q_fix = neg_q ? W'(-quo) : quo;
  assign r_fix = neg_r ? W'(-rem[W-1:0]) : rem[W-1:0];

  assign bus.stallreq_c = bus.start && !bus.ready && !bus.annul;

  // State register and registered datapath/outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      dvs        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      bus.result <= '0;
      bus.ready  <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      rem        <= rem_next;
      quo        <= quo_next;
      dvs        <= dvs_next;
      neg_q      <= neg_q_next;
      neg_r      <= neg_r_next;
      bus.result <= result_next;
      bus.ready  <= ready_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (div_zero)   state_next = S_BY_ZERO;
          else if (early) state_next = S_END;
          else            state_next = S_ON;
        end
      end
      S_BY_ZERO: state_next = bus.annul ? S_IDLE : S_END;
      S_ON: begin
        if (bus.annul)      state_next = S_IDLE;
        else if (last_iter) state_next = S_END;
      end
      S_END: begin
        if (!bus.start) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_next    = cnt;
    rem_next    = rem;
    quo_next    = quo;
    dvs_next    = dvs;
    neg_q_next  = neg_q;
    neg_r_next  = neg_r;
    result_next = bus.result;
    ready_next  = bus.ready;

    if (state == S_IDLE && state_next == S_ON) begin
      cnt_next   = '0;
      rem_next   = '0;
      quo_next   = abs1;
      dvs_next   = abs2;
      neg_q_next = bus.signed_div && (bus.opdata1[W-1] ^ bus.opdata2[W-1]);
      neg_r_next = bus.signed_div && bus.opdata1[W-1];
    end else if (state == S_ON && state_next == S_ON) begin
      rem_next = borrow ? rem_sh : diff[W:0];
      quo_next = {quo[W-2:0], ~borrow};
      cnt_next = cnt + CNT_W'(1);
    end

    case (state_next)
      S_IDLE: begin
        result_next = '0;
        ready_next  = 1'b0;
      end
      S_END: begin
        if (state != S_END) begin
          ready_next = 1'b1;
          case (state)
            S_ON:    result_next = {r_fix, q_fix};
            S_IDLE:  result_next = {bus.opdata1, W'(0)};
            default: result_next = '0;
          endcase
        end
      end
      default: begin
        result_next = '0;
        ready_next  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: scoreboard of expected {remainder, quotient} words.
module tb_div_seq;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_seq_if #(.DATA_W(W)) bus();

  div_seq #(.DATA_W(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [2*W-1:0] sb_q[$];

  // Reference quotient/remainder using 64-bit truncating division
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sgn);
    longint sa, sd, q, r;
    if (b == '0) return '0;
    if (sgn) begin
      sa = {{32{a[W-1]}}, a};
      sd = {{32{b[W-1]}}, b};
    end else begin
      sa = {32'd0, a};
      sd = {32'd0, b};
    end
    q = sa / sd;
    r = sa % sd;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  // Clock edges from the start-sampling edge up to the one that raises ready, inclusive
  function automatic int exp_edges(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sgn);
    logic [W-1:0] ma, mb;
    if (b == '0) return 2;
    ma = (sgn && a[W-1]) ? W'(-a) : a;
    mb = (sgn && b[W-1]) ? W'(-b) : b;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    if (ma == mb) return W + 2;
    return W + 2;
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                       input string name);
    int n;
    int lat;
    logic stall_bad;
    logic [2*W-1:0] exp;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.annul      = 1'b0;
    bus.signed_div = sgn;
    bus.opdata1    = a;
    bus.opdata2    = b;
    sb_q.push_back(model(a, b, sgn));
    lat = exp_edges(a, b, sgn);
    #1;
    stall_bad = !bus.stallreq_c;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!bus.ready && !bus.stallreq_c) stall_bad = 1'b1;
    end while (!bus.ready && n < 200);
    exp = sb_q.pop_front();
    checks++;
    if (!bus.ready) begin
      failures++;
      $display("FAIL %s timeout: ready=%b after %0d edges, required 1", name, bus.ready, n);
    end else begin
      checks++;
      if (n !== lat) begin
        failures++;
        $display("FAIL %s latency: got %0d edges, required %0d", name, n, lat);
      end
      checks++;
      if (stall_bad || bus.stallreq_c !== 1'b0) begin
        failures++;
        $display("FAIL %s stallreq: waiting-stall broken=%b, at-ready=%b required 0",
                 name, stall_bad, bus.stallreq_c);
      end
      checks++;
      if (bus.result !== exp) begin
        failures++;
        $display("FAIL %s result: got %h, required %h", name, bus.result, exp);
      end
      // Start held high in END must not launch a new op
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (bus.ready !== 1'b1 || bus.result !== exp) begin
        failures++;
        $display("FAIL %s hold: ready=%b result=%h, required 1/%h", name, bus.ready,
                 bus.result, exp);
      end
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.result !== '0) begin
      failures++;
      $display("FAIL %s release: ready=%b result=%h, required 0/0", name, bus.ready, bus.result);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.annul = 1'b0; bus.signed_div = 1'b0;
    bus.opdata1 = '0; bus.opdata2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.result !== '0 || bus.stallreq_c !== 1'b0) begin
      failures++;
      $display("FAIL reset: ready=%b result=%h stall=%b, required 0/0/0",
               bus.ready, bus.result, bus.stallreq_c);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_divu();
    do_op(32'd100, 32'd7, 1'b0, "divu_100_7");
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, "divu_max_1");
    do_op(32'hDEAD_BEEF, 32'h0001_2345, 1'b0, "divu_mixed");
  endtask

  task automatic test_signed();
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
    do_op(32'd100, 32'hFFFF_FFF9, 1'b1, "div_100_m7");
    do_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, "div_m100_m7");
  endtask

  task automatic test_by_zero();
    do_op(32'd5, 32'd0, 1'b0, "divu_by_zero");
    do_op(32'hFFFF_FFF0, 32'd0, 1'b1, "div_by_zero");
  endtask

  task automatic test_annul();
    // Annul while idle blocks the start
    @(negedge clk);
    bus.start = 1'b1; bus.annul = 1'b1; bus.signed_div = 1'b0;
    bus.opdata1 = 32'd50; bus.opdata2 = 32'd5;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (bus.ready !== 1'b0 || bus.stallreq_c !== 1'b0) begin
        failures++;
        $display("FAIL annul_idle: ready=%b stall=%b, required 0/0", bus.ready, bus.stallreq_c);
      end
    end
    bus.start = 1'b0; bus.annul = 1'b0;
    // Annul mid-iteration at cnt=10
    @(negedge clk);
    bus.start = 1'b1; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3;
    repeat (11) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    #1;
    checks++;
    if (bus.stallreq_c !== 1'b0) begin
      failures++;
      $display("FAIL annul_stall: stall=%b, required 0", bus.stallreq_c);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.result !== '0) begin
      failures++;
      $display("FAIL annul_on: ready=%b result=%h, required 0/0", bus.ready, bus.result);
    end
    bus.start = 1'b0; bus.annul = 1'b0;
    repeat (36) begin
      @(posedge clk); #1;
      checks++;
      if (bus.ready !== 1'b0) begin
        failures++;
        $display("FAIL annul_quiet: ready=%b, required 0", bus.ready);
      end
    end
    do_op(32'd9, 32'd3, 1'b0, "after_annul_9_3");
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    bus.start = 1'b1; bus.annul = 1'b0; bus.signed_div = 1'b0;
    bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.result !== '0) begin
      failures++;
      $display("FAIL rst_mid: ready=%b result=%h, required 0/0", bus.ready, bus.result);
    end
    rst = 1'b0; bus.start = 1'b0;
    repeat (36) @(posedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_quiet: ready=%b, required 0", bus.ready);
    end
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_overflow");
  endtask

  task automatic test_small();
    do_op(32'd3, 32'd10, 1'b0, "divu_3_10");
    do_op(32'hFFFF_FFFD, 32'd10, 1'b1, "div_m3_10");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic sgn;
    for (int i = 0; i < 8; i++) begin
      a   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       b = W'($urandom_range(1, 15));
        1:       b = '0;
        default: b = $urandom;
      endcase
      do_op(a, b, sgn, $sformatf("b2b_%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_by_zero();
    test_annul();
    test_rst_mid();
    test_small();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
